// File: rtl/cod2outof5_multidigit_display.sv
// Captures 2-of-5 barcode digits into a shift register and drives a scanned 7-segment display plus status LEDs.
// Latency: a capture lands in the entry store at the strobe edge; seg/dig/ledG/ledR follow one cycle later.
// Backpressure: none; a strobe is accepted every cycle, and clear wins over a simultaneous strobe.
// Build option: define ERR_BLINK_EN to make error entries blink instead of showing a steady "E".
module cod2outof5_multidigit_display #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [4:0]                      code_in,
  input  logic                            code_valid,
  input  logic                            clear,
  output logic [6:0]                      seg,
  output logic [NUM_DIGITS-1:0]           dig,
  output logic                            ledG,
  output logic                            ledR,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count
);

  localparam int CW    = $clog2(NUM_DIGITS + 1);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0]    COUNT_FULL = CW'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0] GLYPH_E = 7'b1111001;

  // Reject configurations outside the supported range at elaboration time.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("NUM_DIGITS must be in 1..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 2");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("BLINK_DIV must be at least 1");
  end

  typedef enum logic [1:0] {
    E_BLANK = 2'd0,
    E_VALID = 2'd1,
    E_ERROR = 2'd2
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] val;
  } entry_t;

  localparam entry_t BLANK_ENTRY = '{kind: E_BLANK, val: 4'd0};

  // Map a 2-of-5 code to a stored entry; anything outside the ten legal codes is an error entry.
  function automatic entry_t decode(input logic [4:0] c);
    entry_t e;
    e.kind = E_VALID;
    e.val  = 4'd0;
    case (c)
      5'b00110: e.val = 4'd0;
      5'b10001: e.val = 4'd1;
      5'b01001: e.val = 4'd2;
      5'b11000: e.val = 4'd3;
      5'b00101: e.val = 4'd4;
      5'b10100: e.val = 4'd5;
      5'b01100: e.val = 4'd6;
      5'b00011: e.val = 4'd7;
      5'b10010: e.val = 4'd8;
      5'b01010: e.val = 4'd9;
      default:  e.kind = E_ERROR;
    endcase
    return e;
  endfunction

  // Segment pattern {g,f,e,d,c,b,a} for a decimal value.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'b0111111;
      4'd1:    g = 7'b0000110;
      4'd2:    g = 7'b1011011;
      4'd3:    g = 7'b1001111;
      4'd4:    g = 7'b1100110;
      4'd5:    g = 7'b1101101;
      4'd6:    g = 7'b1111101;
      4'd7:    g = 7'b0000111;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1101111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  entry_t           entries_q [NUM_DIGITS];
  entry_t           entries_d [NUM_DIGITS];
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] scan_cnt_q;
  logic [IDX_W-1:0] scan_idx_q;
  logic             scan_wrap;
  logic             any_err;
  entry_t           cur_entry;
  logic             show_err;
  logic [6:0]       seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic             ledG_q, ledR_q;

  // Next entry store: clear empties everything, otherwise an enabled strobe shifts a new digit in at entry 0.
  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        entries_d[i] = BLANK_ENTRY;
      end
      count_d = '0;
    end else if (code_valid && en) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        entries_d[i] = entries_q[i-1];
      end
      entries_d[0] = decode(code_in);
      if (count_q != COUNT_FULL) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Entry store and fill counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        entries_q[i] <= BLANK_ENTRY;
      end
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

  assign scan_wrap = (scan_cnt_q == CNT_LAST);

  // Free-running scan divider; the digit index steps each time the divider wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else if (scan_wrap) begin
      scan_cnt_q <= '0;
      scan_idx_q <= (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
    end else begin
      scan_cnt_q <= scan_cnt_q + CNT_W'(1);
    end
  end

`ifdef ERR_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blink_on_q;
  logic          frame_done;

  // A full scan cycle ends when the last digit slot finishes its dwell time.
  assign frame_done = scan_wrap && (scan_idx_q == IDX_LAST);

  // Blink phase flips after every BLINK_DIV complete scan cycles, starting in the visible phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (frame_done) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  assign show_err = blink_on_q;
`else
  assign show_err = 1'b1;
`endif

  // Frame-level error flag: any stored entry holds an invalid code.
  always_comb begin
    any_err = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (entries_q[i].kind == E_ERROR) begin
        any_err = 1'b1;
      end
    end
  end

  assign cur_entry = entries_q[scan_idx_q];

  // Display drive for the currently scanned slot; everything dark while disabled.
  always_comb begin
    seg_d = 7'b0000000;
    dig_d = '0;
    if (en) begin
      dig_d = NUM_DIGITS'(1) << scan_idx_q;
      case (cur_entry.kind)
        E_VALID: seg_d = glyph(cur_entry.val);
        E_ERROR: seg_d = show_err ? GLYPH_E : 7'b0000000;
        default: seg_d = 7'b0000000;
      endcase
    end
  end

  // Registered display and status outputs; the LEDs ignore en so the frame status is always visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q  <= 7'b0000000;
      dig_q  <= '0;
      ledR_q <= 1'b0;
      ledG_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dig_q  <= dig_d;
      ledR_q <= any_err;
      ledG_q <= (count_q == COUNT_FULL) && !any_err;
    end
  end

  assign seg         = seg_q;
  assign dig         = dig_q;
  assign ledR        = ledR_q;
  assign ledG        = ledG_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_cod2outof5_multidigit_display.sv
// Directed bench for the multi-digit 2-of-5 display: capture, validation, scanning, LEDs, clear and enable gating.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// Runs with NUM_DIGITS=4 and SCAN_DIV=4 so one full scan takes 16 cycles.
module tb_cod2outof5_multidigit_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [4:0] code_in;
  logic       code_valid;
  logic       clear;
  logic [6:0] seg;
  logic [3:0] dig;
  logic       ledG;
  logic       ledR;
  logic [2:0] digit_count;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] G0 = 7'b0111111;
  localparam logic [6:0] G1 = 7'b0000110;
  localparam logic [6:0] G2 = 7'b1011011;
  localparam logic [6:0] G3 = 7'b1001111;
  localparam logic [6:0] G4 = 7'b1100110;
  localparam logic [6:0] G5 = 7'b1101101;
  localparam logic [6:0] G6 = 7'b1111101;
  localparam logic [6:0] G7 = 7'b0000111;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] G9 = 7'b1101111;
  localparam logic [6:0] GE = 7'b1111001;
  localparam logic [6:0] GB = 7'b0000000;

  always #5 clk = ~clk;

  cod2outof5_multidigit_display #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (4),
    .BLINK_DIV (256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .code_in    (code_in),
    .code_valid (code_valid),
    .clear      (clear),
    .seg        (seg),
    .dig        (dig),
    .ledG       (ledG),
    .ledR       (ledR),
    .digit_count(digit_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One capture strobe; consecutive calls give back-to-back strobes.
  task automatic load(input logic [4:0] c);
    code_in    = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  // Advance until the given digit select is shown, bounded by 24 cycles.
  task automatic wait_dig(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 24 && !ok; i++) begin
      tick();
      if (dig === want) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_dig;
    rst = 1'b1; en = 1'b1; code_valid = 1'b0; clear = 1'b0; code_in = 5'b00000;
    tick();
    tick();
    checks++; if (seg !== GB) begin errors++; $display("FAIL reset_seg: got %b, expected %b", seg, GB); end
    checks++; if (dig !== 4'b0000) begin errors++; $display("FAIL reset_dig: got %b, expected 0000", dig); end
    checks++; if (ledG !== 1'b0) begin errors++; $display("FAIL reset_ledG: got %b, expected 0", ledG); end
    checks++; if (ledR !== 1'b0) begin errors++; $display("FAIL reset_ledR: got %b, expected 0", ledR); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", digit_count); end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_dig = 4'(1 << (k / 4));
      checks++;
      if (dig !== exp_dig) begin
        errors++; $display("FAIL scan_walk cycle %0d: dig=%b, expected %b", k, dig, exp_dig);
      end
    end
    checks++; if (seg !== GB) begin errors++; $display("FAIL scan_walk_blank_seg: got %b, expected %b", seg, GB); end
  endtask

  task automatic test_load();
    logic [6:0] exp_s [4];
    bit ok;
    exp_s = '{G4, G3, G2, G1};
    load(5'b10001);
    load(5'b01001);
    load(5'b11000);
    load(5'b00101);
    tick();
    checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL load_count: got %0d, expected 4", digit_count); end
    checks++; if (ledG !== 1'b1) begin errors++; $display("FAIL load_ledG: got %b, expected 1", ledG); end
    checks++; if (ledR !== 1'b0) begin errors++; $display("FAIL load_ledR: got %b, expected 0", ledR); end
    for (int s = 0; s < 4; s++) begin
      wait_dig(4'(1 << s), ok);
      checks++;
      if (!ok || seg !== exp_s[s]) begin
        errors++; $display("FAIL load_slot%0d: seg=%b dig=%b, expected seg=%b", s, seg, dig, exp_s[s]);
      end
    end
  endtask

  task automatic test_errors();
    logic [6:0] exp_e [3];
    logic [6:0] exp_s [4];
    bit ok;
    exp_e = '{GE, GE, G4};
    exp_s = '{G6, G9, G8, G0};
    load(5'b11100);
    load(5'b00000);
    tick();
    checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL err_count: got %0d, expected 4", digit_count); end
    checks++; if (ledR !== 1'b1) begin errors++; $display("FAIL err_ledR: got %b, expected 1", ledR); end
    checks++; if (ledG !== 1'b0) begin errors++; $display("FAIL err_ledG: got %b, expected 0", ledG); end
    for (int s = 0; s < 3; s++) begin
      wait_dig(4'(1 << s), ok);
      checks++;
      if (!ok || seg !== exp_e[s]) begin
        errors++; $display("FAIL err_slot%0d: seg=%b dig=%b, expected seg=%b", s, seg, dig, exp_e[s]);
      end
    end
    load(5'b00110);
    load(5'b10010);
    load(5'b01010);
    tick();
    checks++; if (ledR !== 1'b1) begin errors++; $display("FAIL err_top_ledR: got %b, expected 1", ledR); end
    load(5'b01100);
    tick();
    checks++; if (ledR !== 1'b0) begin errors++; $display("FAIL err_shifted_out_ledR: got %b, expected 0", ledR); end
    checks++; if (ledG !== 1'b1) begin errors++; $display("FAIL err_shifted_out_ledG: got %b, expected 1", ledG); end
    for (int s = 0; s < 4; s++) begin
      wait_dig(4'(1 << s), ok);
      checks++;
      if (!ok || seg !== exp_s[s]) begin
        errors++; $display("FAIL err_recover_slot%0d: seg=%b dig=%b, expected seg=%b", s, seg, dig, exp_s[s]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [6:0] exp_s [4];
    bit ok;
    exp_s = '{G0, G6, G9, G8};
    load(5'b00110);
    tick();
    checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL sat_count: got %0d, expected 4", digit_count); end
    checks++; if (ledG !== 1'b1) begin errors++; $display("FAIL sat_ledG: got %b, expected 1", ledG); end
    for (int s = 0; s < 4; s++) begin
      wait_dig(4'(1 << s), ok);
      checks++;
      if (!ok || seg !== exp_s[s]) begin
        errors++; $display("FAIL sat_slot%0d: seg=%b dig=%b, expected seg=%b", s, seg, dig, exp_s[s]);
      end
    end
  endtask

  task automatic test_clear_collision();
    bit ok;
    clear      = 1'b1;
    code_valid = 1'b1;
    code_in    = 5'b00110;
    tick();
    clear      = 1'b0;
    code_valid = 1'b0;
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL clr_count: got %0d, expected 0", digit_count); end
    tick();
    checks++; if (ledG !== 1'b0) begin errors++; $display("FAIL clr_ledG: got %b, expected 0", ledG); end
    checks++; if (ledR !== 1'b0) begin errors++; $display("FAIL clr_ledR: got %b, expected 0", ledR); end
    for (int s = 0; s < 4; s++) begin
      wait_dig(4'(1 << s), ok);
      checks++;
      if (!ok || seg !== GB) begin
        errors++; $display("FAIL clr_slot%0d: seg=%b dig=%b, expected seg=%b", s, seg, dig, GB);
      end
    end
  endtask

  task automatic test_glyphs();
    logic [6:0] exp_s [4];
    bit ok;
    exp_s = '{G3, G2, G7, G5};
    load(5'b10100);
    tick();
    checks++; if (digit_count !== 3'd1) begin errors++; $display("FAIL partial_count: got %0d, expected 1", digit_count); end
    checks++; if (ledG !== 1'b0) begin errors++; $display("FAIL partial_ledG: got %b, expected 0", ledG); end
    wait_dig(4'b0001, ok);
    checks++; if (!ok || seg !== G5) begin errors++; $display("FAIL partial_slot0: seg=%b dig=%b, expected seg=%b", seg, dig, G5); end
    wait_dig(4'b0010, ok);
    checks++; if (!ok || seg !== GB) begin errors++; $display("FAIL partial_slot1: seg=%b dig=%b, expected seg=%b", seg, dig, GB); end
    load(5'b00011);
    load(5'b01001);
    load(5'b11000);
    tick();
    checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL glyph_count: got %0d, expected 4", digit_count); end
    checks++; if (ledG !== 1'b1) begin errors++; $display("FAIL glyph_ledG: got %b, expected 1", ledG); end
    for (int s = 0; s < 4; s++) begin
      wait_dig(4'(1 << s), ok);
      checks++;
      if (!ok || seg !== exp_s[s]) begin
        errors++; $display("FAIL glyph_slot%0d: seg=%b dig=%b, expected seg=%b", s, seg, dig, exp_s[s]);
      end
    end
  endtask

  task automatic test_enable_gate();
    bit ok;
    en = 1'b0;
    load(5'b00110);
    load(5'b10001);
    tick();
    checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL gate_count: got %0d, expected 4", digit_count); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (seg !== GB || dig !== 4'b0000) begin
        errors++; $display("FAIL gate_dark cycle %0d: seg=%b dig=%b, expected 0000000/0000", k, seg, dig);
      end
    end
    en = 1'b1;
    wait_dig(4'b0001, ok);
    checks++; if (!ok || seg !== G3) begin errors++; $display("FAIL gate_resume_slot0: seg=%b dig=%b, expected seg=%b", seg, dig, G3); end
    wait_dig(4'b1000, ok);
    checks++; if (!ok || seg !== G5) begin errors++; $display("FAIL gate_resume_slot3: seg=%b dig=%b, expected seg=%b", seg, dig, G5); end
    en    = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL gate_clear_count: got %0d, expected 0", digit_count); end
    tick();
    checks++; if (ledG !== 1'b0) begin errors++; $display("FAIL gate_clear_ledG: got %b, expected 0", ledG); end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load();
    test_errors();
    test_saturate();
    test_clear_collision();
    test_glyphs();
    test_enable_gate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
